// File: rtl/clock_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_gen_if
// Brief    : Control and strobe bundle between a clock_gen and its user.
// Revision : 1.0 - initial release
// ============================================================================
interface clock_gen_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             load;
    logic [CNT_W-1:0] half_period_i;
    logic             clk_out;
    logic             rise;
    logic             fall;

    modport master (
        output en,
        output load,
        output half_period_i,
        input  clk_out,
        input  rise,
        input  fall
    );

    modport slave (
        input  en,
        input  load,
        input  half_period_i,
        output clk_out,
        output rise,
        output fall
    );
endinterface
`default_nettype wire

// File: rtl/clock_gen.sv
`default_nettype none
// ============================================================================
// Module   : clock_gen
// Brief    : Programmable 50%-duty clock divider with rise/fall edge strobes.
// Revision : 1.0 - initial release
// ============================================================================
module clock_gen #(
    parameter int HALF_PERIOD = 12,
    parameter int CNT_W       = 16
) (
    input  wire logic  clock,
    input  wire logic  reset,
    clock_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] c_HALF_RST = CNT_W'(HALF_PERIOD);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_count;
    logic             r_clk_out;
    logic             r_rise;
    logic             r_fall;

    logic             w_terminal;
    logic [CNT_W-1:0] w_load_half;

    assign w_terminal  = (r_count == (r_half - c_ONE));
    // A zero half-period would never terminate; treat it as the fastest rate.
    assign w_load_half = (bus.half_period_i == '0) ? c_ONE : bus.half_period_i;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_half    <= c_HALF_RST;
            r_count   <= '0;
            r_clk_out <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else if (bus.load) begin
            r_half    <= w_load_half;
            r_count   <= '0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else if (bus.en) begin
            if (w_terminal) begin
                r_count   <= '0;
                r_clk_out <= ~r_clk_out;
                r_rise    <= ~r_clk_out;
                r_fall    <= r_clk_out;
            end else begin
                r_count   <= r_count + c_ONE;
                r_rise    <= 1'b0;
                r_fall    <= 1'b0;
            end
        end else begin
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end
    end

    assign bus.clk_out = r_clk_out;
    assign bus.rise    = r_rise;
    assign bus.fall    = r_fall;

endmodule
`default_nettype wire

// File: tb/tb_clock_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_gen
// Brief    : Randomized and directed self-checking bench for clock_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_gen;
    localparam int CNT_W = 16;
    localparam int HP    = 12;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    clock_gen_if #(.CNT_W(CNT_W)) bus ();

    clock_gen #(.HALF_PERIOD(HP), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference: the output level is the level at the last load/reset epoch,
    // flipped once for every completed half-period of enabled cycles since then.
    int   m_half = HP;
    int   m_n    = 0;
    logic m_base = 1'b0;
    logic m_clk  = 1'b0;
    logic m_rise = 1'b0;
    logic m_fall = 1'b0;

    task automatic step(input logic r, input logic e, input logic l, input int hp);
        logic nclk;
        reset             = r;
        bus.en            = e;
        bus.load          = l;
        bus.half_period_i = CNT_W'(hp);
        @(posedge clock);
        if (r) begin
            m_half = HP; m_n = 0; m_base = 1'b0; m_clk = 1'b0;
            m_rise = 1'b0; m_fall = 1'b0;
        end else if (l) begin
            m_base = m_clk; m_n = 0;
            m_half = ((hp % (1 << CNT_W)) == 0) ? 1 : (hp % (1 << CNT_W));
            m_rise = 1'b0; m_fall = 1'b0;
        end else if (e) begin
            m_n    = m_n + 1;
            nclk   = m_base ^ logic'((m_n / m_half) % 2);
            m_rise = nclk & ~m_clk;
            m_fall = ~nclk & m_clk;
            m_clk  = nclk;
        end else begin
            m_rise = 1'b0; m_fall = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 1, 1, 5);
        n_total++;
        if ({bus.clk_out, bus.rise, bus.fall} !== 3'b000) $display("FAIL reset_outputs: got %b want 000", {bus.clk_out, bus.rise, bus.fall});
        else n_pass++;
        n_total++;
        if (dut.r_half !== 16'd12 || dut.r_count !== 16'd0) $display("FAIL reset_state: got half=%0d count=%0d want 12/0", dut.r_half, dut.r_count);
        else n_pass++;
    endtask

    task automatic test_default();
        logic er, ef;
        int bad_model = 0, bad_edge = 0;
        step(1, 0, 0, 0);
        for (int k = 1; k <= 60; k++) begin
            step(0, 1, 0, 0);
            er = (k == 12 || k == 36 || k == 60);
            ef = (k == 24 || k == 48);
            if ({bus.rise, bus.fall} !== {er, ef}) begin
                if (bad_edge == 0) $display("FAIL default_edges: edge %0d got rise/fall=%b want %b", k, {bus.rise, bus.fall}, {er, ef});
                bad_edge++;
            end
            if ({bus.clk_out, bus.rise, bus.fall} !== {m_clk, m_rise, m_fall}) begin
                if (bad_model == 0) $display("FAIL default_model: edge %0d got %b want %b", k, {bus.clk_out, bus.rise, bus.fall}, {m_clk, m_rise, m_fall});
                bad_model++;
            end
        end
        n_total++; if (bad_edge == 0) n_pass++;
        n_total++; if (bad_model == 0) n_pass++;
        n_total++;
        if (bus.clk_out !== 1'b1) $display("FAIL default_level60: got %b want 1", bus.clk_out);
        else n_pass++;
    endtask

    task automatic test_load3();
        int bad = 0, rises = 0, falls = 0;
        step(1, 0, 0, 0);
        step(0, 0, 1, 3);
        for (int k = 1; k <= 24; k++) begin
            step(0, 1, 0, 0);
            rises += int'(bus.rise);
            falls += int'(bus.fall);
            if ({bus.clk_out, bus.rise, bus.fall} !== {m_clk, m_rise, m_fall} ||
                (bus.rise && bus.fall) ||
                ({bus.rise, bus.fall} !== {(k % 6) == 3, (k % 6) == 0})) begin
                if (bad == 0) $display("FAIL load3_wave: edge %0d got %b want %b", k, {bus.clk_out, bus.rise, bus.fall}, {m_clk, m_rise, m_fall});
                bad++;
            end
        end
        n_total++; if (bad == 0) n_pass++;
        n_total++;
        if (rises != 4 || falls != 4) $display("FAIL load3_counts: got rises=%0d falls=%0d want 4/4", rises, falls);
        else n_pass++;
    endtask

    task automatic test_load0();
        int bad = 0;
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        n_total++;
        if (dut.r_half !== 16'd1) $display("FAIL load0_half: got %0d want 1", dut.r_half);
        else n_pass++;
        for (int k = 1; k <= 10; k++) begin
            step(0, 1, 0, 0);
            if ({bus.clk_out, bus.rise, bus.fall} !== {k[0], k[0], ~k[0]}) begin
                if (bad == 0) $display("FAIL load0_wave: edge %0d got %b want %b", k, {bus.clk_out, bus.rise, bus.fall}, {k[0], k[0], ~k[0]});
                bad++;
            end
        end
        n_total++; if (bad == 0) n_pass++;
    endtask

    task automatic test_en_gap();
        int bad = 0, wait_n = 0;
        step(1, 0, 0, 0);
        for (int k = 0; k < 7; k++) step(0, 1, 0, 0);
        n_total++;
        if (dut.r_count !== 16'd7) $display("FAIL gap_count: got %0d want 7", dut.r_count);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0);
            if ({bus.clk_out, bus.rise, bus.fall} !== 3'b000) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL gap_hold: got %0d bad cycles want 0", bad);
        else n_pass++;
        do begin
            step(0, 1, 0, 0);
            wait_n++;
        end while (!bus.rise && wait_n < 30);
        n_total++;
        if (wait_n != 5 || bus.clk_out !== m_clk) $display("FAIL gap_resume: got %0d cycles to rise want 5", wait_n);
        else n_pass++;
    endtask

    task automatic test_load_terminal();
        int wait_n = 0;
        step(1, 0, 0, 0);
        for (int k = 0; k < 11; k++) step(0, 1, 0, 0);
        step(0, 1, 1, 4);
        n_total++;
        if ({bus.clk_out, bus.rise, bus.fall} !== 3'b000 || dut.r_count !== 16'd0 || dut.r_half !== 16'd4)
            $display("FAIL term_load: got out=%b count=%0d half=%0d want 000/0/4", {bus.clk_out, bus.rise, bus.fall}, dut.r_count, dut.r_half);
        else n_pass++;
        do begin
            step(0, 1, 0, 0);
            wait_n++;
        end while (!bus.rise && wait_n < 20);
        n_total++;
        if (wait_n != 4 || m_rise !== 1'b1) $display("FAIL term_next: got %0d cycles to rise want 4", wait_n);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 0);
        step(0, 1, 1, 5);
        for (int k = 0; k < 7; k++) step(0, 1, 0, 0);
        n_total++;
        if (bus.clk_out !== 1'b1 || m_clk !== 1'b1) $display("FAIL mid_high: got %b want 1", bus.clk_out);
        else n_pass++;
        step(1, 1, 0, 0);
        n_total++;
        if ({bus.clk_out, bus.rise, bus.fall} !== 3'b000 || dut.r_count !== 16'd0 || dut.r_half !== 16'd12)
            $display("FAIL mid_reset: got out=%b count=%0d half=%0d want 000/0/12", {bus.clk_out, bus.rise, bus.fall}, dut.r_count, dut.r_half);
        else n_pass++;
    endtask

    task automatic test_random();
        int bad = 0;
        logic r, e, l;
        step(1, 0, 0, 0);
        for (int k = 0; k < 600; k++) begin
            r = ($urandom_range(0, 99) == 0);
            l = ($urandom_range(0, 19) == 0);
            e = ($urandom_range(0, 3) != 0);
            step(r, e, l, int'($urandom_range(0, 6)));
            if ({bus.clk_out, bus.rise, bus.fall} !== {m_clk, m_rise, m_fall}) begin
                if (bad == 0) $display("FAIL random_model: step %0d got %b want %b", k, {bus.clk_out, bus.rise, bus.fall}, {m_clk, m_rise, m_fall});
                bad++;
            end
        end
        n_total++; if (bad == 0) n_pass++;
    endtask

    initial begin
        bus.en            = 1'b0;
        bus.load          = 1'b0;
        bus.half_period_i = '0;
        test_reset();
        test_default();
        test_load3();
        test_load0();
        test_en_gap();
        test_load_terminal();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
